chdr_fifo_to_radio_demux: RTL and testbench
===========================================

Name: chdr_fifo_to_radio_demux

Overview:
Parametrised successor of the single-radio deep-FIFO drain stage. It reads CHDR packets from the post-deep-FIFO AXI-Stream (64-bit), qualifies each header, and routes valid data packets to one of NUM_CHAN radio TX ports, generating tlast from the header length. Malformed or unroutable packets are drained rather than stalling the stream, and counted. It sits between the host-to-card deep FIFO and the per-channel radio TX cores.

Parameters:
NUM_CHAN, 2, number of radio TX output channels (1..4)
DATA_SID_BASE, 32'h50, masked SID of channel 0
SID_STRIDE, 32'h10, masked-SID increment per channel (channel i = DATA_SID_BASE + i*SID_STRIDE)
SID_MASK, 32'hffff_fff0, mask applied to header SID before matching
MAX_PKT_BYTES, 1472, largest legal CHDR length field in bytes

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
s_tdata  in  64  stream from deep FIFO
s_tvalid  in  1  input valid
s_tready  out  1  input ready
m_tdata  out  64*NUM_CHAN  per-channel data, channel i at [64*i+63:64*i]
m_tvalid  out  NUM_CHAN  per-channel valid
m_tlast  out  NUM_CHAN  per-channel last
m_tready  in  NUM_CHAN  per-channel ready
drop_cnt  out  16  packets dumped (unknown SID/type), saturating
err_cnt  out  16  words discarded in ERROR resync, saturating
active_chan  out  2  channel index of the current/last routed packet

Behaviour:
- Header fields on s_tdata: type = {[63:62],[60]}; len_bytes = [47:32]; sid = [31:0]. Data types accepted: 3'b000, 3'b001 (EOB), 3'b010 (FC).
- len_ok: 8 <= len_bytes <= MAX_PKT_BYTES. pkt_len (QWORDs, header included) = len_bytes[15:3] + |len_bytes[2:0]; 13-bit result zero-extended to 16.
- Channel match: hit[i] = ((sid & SID_MASK) == DATA_SID_BASE + i*SID_STRIDE). Lowest index wins if several hit.
- States (one-hot): IDLE, CHECK_HEAD, DATA_PKT, DUMP, ERROR. Reset -> IDLE, counters 0, active_chan 0, word counter 0.
- IDLE: s_tready=0; s_tvalid -> CHECK_HEAD.
- CHECK_HEAD (header not consumed, s_tready=0): data type & len_ok & any hit -> latch pkt_len, channel, goto DATA_PKT. len_ok but bad type or no hit -> latch pkt_len, goto DUMP. !len_ok -> ERROR.
- DATA_PKT: m_tvalid[ch] = s_tvalid, other channels 0; m_tdata of all channels = s_tdata; s_tready = m_tready[ch]. Counter increments per beat; m_tlast[ch] = (cnt == pkt_len-1), independent of m_tready (AXI-compliant, stable while valid). On last beat: counter 0, goto IDLE.
- DUMP: s_tready=1, outputs idle; same counter; on beat pkt_len-1 -> drop_cnt+1, goto IDLE.
- ERROR: s_tready=1 for exactly one beat (the bad header word), err_cnt+1, goto IDLE to resync on next word.
- Latency: first output beat no earlier than 2 cycles after s_tvalid rises in IDLE; throughput 1 beat/cycle within a packet.
- Backpressure: m_tready low holds state and counter; s_tvalid low mid-packet deasserts m_tvalid, counter holds.
- Counters saturate at 16'hffff. pkt_len=1 (header-only) legal: header beat is also tlast.
- rst mid-packet: abandon packet immediately, all outputs deasserted next cycle; no partial flush.
- NUM_CHAN=1: active_chan fixed 0.

Test Plan:
- Ch0 packet: header type 000, sid 0x50, len 32 -> 4 beats on m_*[0], m_tlast on beat 4 only, m_tvalid[1]=0 throughout.
- Ch1 packet sid 0x61, len 20 -> pkt_len 3, routed to channel 1, active_chan=1, tlast on beat 3.
- Unknown sid 0x70, len 24 -> 3 words consumed with s_tready=1, no m_tvalid, drop_cnt=1; following valid ch0 packet forwarded intact.
- Header len 2000 -> one word consumed, err_cnt=1, next word re-examined as header.
- Random m_tready/s_tvalid toggling on 1472-byte ch0 packet -> 184 beats, data order preserved, tlast asserted and stable before handshake.
- rst asserted on beat 5 of 10-beat packet -> all m_tvalid=0 next cycle, counters 0, next header routed correctly.

Source files
------------

// File: rtl/chdr_fifo_to_radio_demux.sv
// CHDR deep-FIFO drain stage: qualifies each packet header, routes data packets
// to one of NUM_CHAN radio TX streams with tlast derived from the header length,
// and drains malformed or unroutable packets so the input stream never stalls.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for a header word to appear on the input
// CHECK_HEAD | header on s_tdata, not consumed yet; decode and pick route
// DATA_PKT   | forwarding the packet (header included) to the chosen channel
// DUMP       | consuming a well-formed but unroutable packet, drop_cnt at end
// ERROR      | consuming the single bad header word, then resync on next word
module chdr_fifo_to_radio_demux #(
    parameter int          NUM_CHAN      = 2,
    parameter logic [31:0] DATA_SID_BASE = 32'h50,
    parameter logic [31:0] SID_STRIDE    = 32'h10,
    parameter logic [31:0] SID_MASK      = 32'hffff_fff0,
    parameter int          MAX_PKT_BYTES = 1472
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [63:0]              s_tdata,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    output logic [64*NUM_CHAN-1:0]   m_tdata,
    output logic [NUM_CHAN-1:0]      m_tvalid,
    output logic [NUM_CHAN-1:0]      m_tlast,
    input  logic [NUM_CHAN-1:0]      m_tready,
    output logic [15:0]              drop_cnt,
    output logic [15:0]              err_cnt,
    output logic [1:0]               active_chan
);

    typedef enum logic [4:0] {
        IDLE       = 5'b00001,
        CHECK_HEAD = 5'b00010,
        DATA_PKT   = 5'b00100,
        DUMP       = 5'b01000,
        ERROR      = 5'b10000
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] word_cnt;
    logic [15:0] pkt_len;
    logic [1:0]  chan;

    logic [2:0]  hdr_type;
    logic [15:0] len_bytes;
    logic [31:0] sid_masked;
    logic        type_ok;
    logic        len_ok;
    logic [15:0] hdr_pkt_len;
    logic        hit_any;
    logic [1:0]  hit_chan;
    logic        last_beat;
    logic        beat;
    logic        unused_hdr_bits;

    assign hdr_type    = {s_tdata[63:62], s_tdata[60]};
    assign len_bytes   = s_tdata[47:32];
    assign sid_masked  = s_tdata[31:0] & SID_MASK;
    assign type_ok     = (hdr_type == 3'b000) || (hdr_type == 3'b001) || (hdr_type == 3'b010);
    assign len_ok      = (len_bytes >= 16'd8) && (len_bytes <= 16'(MAX_PKT_BYTES));
    // Length in QWORDs rounded up; header word is part of the count.
    assign hdr_pkt_len = {3'b000, len_bytes[15:3]} + {15'd0, |len_bytes[2:0]};
    assign last_beat   = (word_cnt == pkt_len - 16'd1);
    assign beat        = s_tvalid && s_tready;
    assign unused_hdr_bits = ^{s_tdata[61], s_tdata[59:48]};

    // Every channel sees the input word; only the routed channel's valid is raised.
    assign m_tdata     = {NUM_CHAN{s_tdata}};
    assign active_chan = (NUM_CHAN == 1) ? 2'd0 : chan;

    // SID match against each channel; scanning downward lets the lowest index win.
    always_comb begin
        hit_any  = 1'b0;
        hit_chan = 2'd0;
        for (int i = NUM_CHAN - 1; i >= 0; i--) begin
            if (sid_masked == DATA_SID_BASE + SID_STRIDE * 32'(i)) begin
                hit_any  = 1'b1;
                hit_chan = 2'(i);
            end
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        s_tready  = 1'b0;
        m_tvalid  = '0;
        m_tlast   = '0;
        case (state)
            IDLE: begin
                if (s_tvalid) state_nxt = CHECK_HEAD;
            end
            CHECK_HEAD: begin
                if (!s_tvalid)                state_nxt = IDLE;
                else if (!len_ok)             state_nxt = ERROR;
                else if (type_ok && hit_any)  state_nxt = DATA_PKT;
                else                          state_nxt = DUMP;
            end
            DATA_PKT: begin
                for (int i = 0; i < NUM_CHAN; i++) begin
                    if (chan == 2'(i)) begin
                        m_tvalid[i] = s_tvalid;
                        m_tlast[i]  = last_beat;
                        s_tready    = m_tready[i];
                    end
                end
                if (beat && last_beat) state_nxt = IDLE;
            end
            DUMP: begin
                s_tready = 1'b1;
                if (s_tvalid && last_beat) state_nxt = IDLE;
            end
            ERROR: begin
                s_tready = 1'b1;
                if (s_tvalid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Packet length/channel latch, beat counter and saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt <= 16'd0;
            pkt_len  <= 16'd0;
            chan     <= 2'd0;
            drop_cnt <= 16'd0;
            err_cnt  <= 16'd0;
        end else begin
            case (state)
                CHECK_HEAD: begin
                    if (s_tvalid && len_ok) begin
                        pkt_len  <= hdr_pkt_len;
                        word_cnt <= 16'd0;
                        if (type_ok && hit_any) chan <= hit_chan;
                    end
                end
                DATA_PKT, DUMP: begin
                    if (beat) begin
                        word_cnt <= last_beat ? 16'd0 : word_cnt + 16'd1;
                        if (state == DUMP && last_beat && drop_cnt != 16'hffff)
                            drop_cnt <= drop_cnt + 16'd1;
                    end
                end
                ERROR: begin
                    if (s_tvalid && err_cnt != 16'hffff) err_cnt <= err_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chdr_fifo_to_radio_demux.sv
// Directed bench for chdr_fifo_to_radio_demux: the stimulus pushes expected
// output beats into a queue, and a negedge monitor pops/compares them.
module tb_chdr_fifo_to_radio_demux;

    localparam int NUM_CHAN = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [63:0]            s_tdata = 64'd0;
    logic                   s_tvalid = 1'b0;
    logic                   s_tready;
    logic [64*NUM_CHAN-1:0] m_tdata;
    logic [NUM_CHAN-1:0]    m_tvalid;
    logic [NUM_CHAN-1:0]    m_tlast;
    logic [NUM_CHAN-1:0]    m_tready = '1;
    logic [15:0]            drop_cnt;
    logic [15:0]            err_cnt;
    logic [1:0]             active_chan;

    typedef struct {
        logic [1:0]  ch;
        logic [63:0] d;
        logic        l;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;
    int   rdy_mode = 0;
    bit   use_gaps = 1'b0;

    chdr_fifo_to_radio_demux #(.NUM_CHAN(NUM_CHAN)) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .drop_cnt(drop_cnt), .err_cnt(err_cnt), .active_chan(active_chan)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [2:0] t, input logic [15:0] len,
                                        input logic [31:0] sid);
        return {t[2:1], 1'b0, t[0], 12'h000, len, sid};
    endfunction

    // Downstream ready: all ones, random, or all zero.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       m_tready = '1;
            1:       m_tready = NUM_CHAN'($urandom_range(0, 3));
            default: m_tready = '0;
        endcase
    end

    // Monitor: every presented beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            if ($countones(m_tvalid) > 1) chk("one_valid", 64'(m_tvalid), 64'd1);
            for (int c = 0; c < NUM_CHAN; c++) begin
                if (m_tvalid[c]) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", 64'(c + 1), 64'd0);
                    end else begin
                        chk("chan",        64'(c),           64'(exp_q[0].ch));
                        chk("data",        m_tdata[64*c +: 64], exp_q[0].d);
                        chk("tlast",       64'(m_tlast[c]),  64'(exp_q[0].l));
                        chk("active_chan", 64'(active_chan), 64'(exp_q[0].ch));
                        if (m_tready[c]) begin
                            void'(exp_q.pop_front());
                            pops++;
                        end
                    end
                end
            end
        end
    end

    task automatic send(input logic [63:0] d);
        int  t;
        bit  hs;
        if (use_gaps) repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
        end
        s_tdata  = d;
        s_tvalid = 1'b1;
        t  = 0;
        hs = 1'b0;
        while (!hs && t < 2000) begin
            @(negedge clk);
            hs = s_tready;
            t++;
        end
        if (!hs) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input logic [2:0] t, input logic [15:0] len, input logic [31:0] sid,
                            input bit routed, input logic [1:0] ch, input logic [7:0] tag);
        int n;
        logic [63:0] w;
        n = int'(len >> 3) + int'(|len[2:0]);
        for (int i = 0; i < n; i++) begin
            w = (i == 0) ? hdr(t, len, sid) : {tag, 24'h0, 32'(i)};
            if (routed) exp_q.push_back('{ch: ch, d: w, l: (i == n - 1)});
            send(w);
        end
    endtask

    task automatic wait_drain(input int budget);
        int t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            @(posedge clk);
            t++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int p0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_drop",     64'(drop_cnt), 64'd0);
        chk("rst_err",      64'(err_cnt),  64'd0);
        chk("rst_active",   64'(active_chan), 64'd0);
        @(posedge clk); #1;

        // Routed packets on both channels, header-only packet, dumps.
        send_pkt(3'b000, 16'd32, 32'h50, 1'b1, 2'd0, 8'hA1);
        wait_drain(50);
        send_pkt(3'b001, 16'd20, 32'h61, 1'b1, 2'd1, 8'hA2);
        wait_drain(50);
        chk("active_ch1", 64'(active_chan), 64'd1);
        send_pkt(3'b000, 16'd24, 32'h70, 1'b0, 2'd0, 8'hA3);
        @(negedge clk);
        chk("drop_sid", 64'(drop_cnt), 64'd1);
        send_pkt(3'b010, 16'd16, 32'h5f, 1'b1, 2'd0, 8'hA4);
        wait_drain(50);
        send_pkt(3'b100, 16'd16, 32'h50, 1'b0, 2'd0, 8'hA5);
        @(negedge clk);
        chk("drop_type", 64'(drop_cnt), 64'd2);
        send_pkt(3'b000, 16'd8, 32'h60, 1'b1, 2'd1, 8'hA6);
        wait_drain(50);

        // Bad lengths: one word consumed each, the following word is a fresh header.
        send(hdr(3'b000, 16'd2000, 32'h50));
        @(negedge clk);
        chk("err_long", 64'(err_cnt), 64'd1);
        send_pkt(3'b000, 16'd24, 32'h50, 1'b1, 2'd0, 8'hA7);
        wait_drain(50);
        send(hdr(3'b000, 16'd4, 32'h60));
        @(negedge clk);
        chk("err_short", 64'(err_cnt), 64'd2);
        chk("drop_hold", 64'(drop_cnt), 64'd2);
        @(posedge clk); #1;

        // Maximum-size packet with random backpressure and input gaps.
        p0 = pops;
        rdy_mode = 1;
        use_gaps = 1'b1;
        send_pkt(3'b000, 16'd1472, 32'h50, 1'b1, 2'd0, 8'hB0);
        wait_drain(3000);
        chk("max_beats", 64'(pops - p0), 64'd184);
        rdy_mode = 0;
        use_gaps = 1'b0;
        @(posedge clk); #1;

        // Reset while beat 5 of a 10-beat packet is presented.
        exp_q.push_back('{ch: 2'd0, d: hdr(3'b000, 16'd80, 32'h50), l: 1'b0});
        send(hdr(3'b000, 16'd80, 32'h50));
        for (int i = 1; i < 4; i++) begin
            exp_q.push_back('{ch: 2'd0, d: {8'hC0, 24'h0, 32'(i)}, l: 1'b0});
            send({8'hC0, 24'h0, 32'(i)});
        end
        rdy_mode = 2;
        s_tdata  = {8'hC0, 24'h0, 32'd4};
        s_tvalid = 1'b1;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        s_tvalid = 1'b0;
        rdy_mode = 0;
        @(negedge clk);
        chk("rst_mid_valid",  64'(m_tvalid), 64'd0);
        chk("rst_mid_drop",   64'(drop_cnt), 64'd0);
        chk("rst_mid_err",    64'(err_cnt),  64'd0);
        chk("rst_mid_active", 64'(active_chan), 64'd0);
        chk("rst_mid_queue",  64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
        send_pkt(3'b000, 16'd16, 32'h65, 1'b1, 2'd1, 8'hD0);
        wait_drain(50);
        chk("post_rst_active", 64'(active_chan), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
